tick_timer_arbiter: RTL

- Shares one mod-M style tick counter among NREQ requesters, each of which needs a programmable delay of M clock cycles.
- Grants the counter to one requester at a time in round-robin order, then runs it from 0 to M-1.
- Pulses a per-requester done when the count reaches M-1.
- Sits between software-visible timing requesters (UART baud gen, debouncers, LED blinkers) and the shared counting datapath.

---
 rtl/tick_timer_arbiter.sv | 107 ++++++++++
 1 files changed

// File: rtl/tick_timer_arbiter.sv
// Round-robin arbiter sharing one mod-M tick counter among NREQ requesters.
// Each grant runs the counter 0..M-1, then pulses done to the owner.
module tick_timer_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = 2,
  parameter int N    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*N-1:0] mval,
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   done,
  output logic              busy,
  output logic [IW-1:0]     owner,
  output logic [N-1:0]      q
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state, state_n;
  logic [IW-1:0] owner_n;
  logic [IW-1:0] last, last_n;
  logic [N-1:0]  lim, lim_n;
  logic [N-1:0]  q_n;
  logic [IW-1:0] win;
  logic          found;
  logic [N-1:0]  m;

  function automatic logic [IW-1:0] wrap(input int v);
    return IW'(v % NREQ);
  endfunction

  // Search last+1, last+2, ... so the previous owner ends up last.
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!found && req[wrap(int'(last) + k)]) begin
        win   = wrap(int'(last) + k);
        found = 1'b1;
      end
    end
  end

  assign m = mval[win*N +: N];

  always_comb begin
    state_n = state;
    owner_n = owner;
    last_n  = last;
    lim_n   = lim;
    q_n     = q;
    unique case (state)
      IDLE: begin
        if (found) begin
          owner_n = win;
          lim_n   = (m == '0) ? '0 : m - 1'b1;
          q_n     = '0;
          state_n = RUN;
        end
      end
      RUN: begin
        if (!req[owner]) begin
          state_n = IDLE;
          q_n     = '0;
          last_n  = owner;
        end else if (q == lim) begin
          state_n = DONE;
          q_n     = '0;
        end else begin
          q_n = q + 1'b1;
        end
      end
      DONE: begin
        last_n  = owner;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      owner <= '0;
      last  <= IW'(NREQ - 1);
      lim   <= '0;
      q     <= '0;
    end else begin
      state <= state_n;
      owner <= owner_n;
      last  <= last_n;
      lim   <= lim_n;
      q     <= q_n;
    end
  end

  assign grant = (state == RUN)  ? (NREQ'(1) << owner) : '0;
  assign done  = (state == DONE) ? (NREQ'(1) << owner) : '0;
  assign busy  = (state != IDLE);

endmodule
